// File: rtl/rv_dp_pkg.sv
// rv_dp_pkg: shared datapath constants, ctrl layout, helpers.
// RVDP_WB_BYPASS_EN enables the WB->ID operand bypass.
package rv_dp_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int CNT_W_DEF = 16;
  localparam int CTRL_W    = 8;

  localparam logic [REG_AW-1:0] X0 = '0;

  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_ALU_SRC   = 4;
  localparam int CTRL_ALU_OP_LO = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

`ifdef RVDP_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  // Live WB write to a non-x0 register matching idx.
  function automatic logic wb_hit(
    input logic              we,
    input logic [REG_AW-1:0] wrd,
    input logic [REG_AW-1:0] idx
  );
    return we && (wrd != X0) && (wrd == idx);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_hazard_detect.sv
// hazard_detect: combinational load-use / WB-dependency detect.
// Ports: EX load info, ID sources, WB port, flush/hold -> bubble, stall_id.
module hazard_detect
  import rv_dp_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush_ex,
  input  logic              hold_ex,
  output logic              bubble,
  output logic              stall_id
);

  logic load_use;
  logic wb_dep;

  always_comb begin
    load_use = ex_valid & ex_mem_read
             & (ex_rd != X0) & id_valid
             & ((ex_rd == id_rs1)
               | (id_use_rs2 & (ex_rd == id_rs2)));
    // Without the bypass the regfile value is only
    // visible next cycle, so wait one cycle.
    wb_dep = ~WB_BYPASS & id_valid
           & (wb_hit(wb_we, wb_rd, id_rs1)
             | (id_use_rs2
               & wb_hit(wb_we, wb_rd, id_rs2)));
    bubble   = load_use | wb_dep;
    stall_id = (bubble | hold_ex) & ~flush_ex;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID->EX register with operand select, bubbles,
// flush/hold and saturating bubble counter. Macro: RVDP_WB_BYPASS_EN.
module id_ex_operand_stage
  import rv_dp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [7:0]        id_ctrl,
  input  logic [XLEN-1:0]   RD1,
  input  logic [XLEN-1:0]   RD2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush_ex,
  input  logic              hold_ex,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic [7:0]        ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [REG_AW-1:0] ex_rs1_idx;
  logic [REG_AW-1:0] ex_rs2_idx;
  logic [XLEN-1:0]   rs1_op;
  logic [XLEN-1:0]   rs2_op;
  logic              bubble;

  hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs2  (id_use_rs2),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .flush_ex    (flush_ex),
    .hold_ex     (hold_ex),
    .bubble      (bubble),
    .stall_id    (stall_id)
  );

  always_comb begin
    rs1_op = RD1;
    if (id_rs1 == X0)
      rs1_op = '0;
    else if (WB_BYPASS
             && wb_hit(wb_we, wb_rd, id_rs1))
      rs1_op = wb_wd;
    rs2_op = RD2;
    if (id_rs2 == X0)
      rs2_op = '0;
    else if (WB_BYPASS
             && wb_hit(wb_we, wb_rd, id_rs2))
      rs2_op = wb_wd;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_valid   <= 1'b0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_rs1_idx <= '0;
      ex_rs2_idx <= '0;
      bubble_cnt <= '0;
    end else if (flush_ex) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (hold_ex) begin
      // Held instruction must not miss a WB
      // result produced while it waits.
      if (ex_valid
          && wb_hit(wb_we, wb_rd, ex_rs1_idx))
        ex_rs1_val <= wb_wd;
      if (ex_valid
          && wb_hit(wb_we, wb_rd, ex_rs2_idx))
        ex_rs2_val <= wb_wd;
    end else if (bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (!(&bubble_cnt))
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_valid   <= id_valid;
      ex_rs1_val <= rs1_op;
      ex_rs2_val <= rs2_op;
      ex_imm     <= id_imm;
      ex_pc      <= id_pc;
      ex_rd      <= id_rd;
      ex_ctrl    <= id_ctrl;
      ex_rs1_idx <= id_rs1;
      ex_rs2_idx <= id_rs2;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table, directed sequences and a
// randomized run against a reference model of the ID->EX stage.
module tb_id_ex_operand_stage;
  import rv_dp_pkg::*;

  localparam int CW  = 10;
  localparam int SAT = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST;
  logic id_valid, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_pc;
  logic [7:0] id_ctrl;
  logic [31:0] RD1, RD2;
  logic wb_we;
  logic [4:0] wb_rd;
  logic [31:0] wb_wd;
  logic flush_ex, hold_ex;
  logic stall_id, ex_valid;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
  logic [4:0] ex_rd;
  logic [7:0] ex_ctrl;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  logic [31:0] regs [32];
  logic rf_init;

  id_ex_operand_stage #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_imm(id_imm),
    .id_pc(id_pc), .id_ctrl(id_ctrl),
    .RD1(RD1), .RD2(RD2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .flush_ex(flush_ex), .hold_ex(hold_ex),
    .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  // Register file: old value readable during the write cycle.
  always @(posedge CLK) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'hBAD0BAD0
                 : 32'(32'h11111111 * i);
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_wd;
    end
  end

  assign RD1 = regs[id_rs1];
  assign RD2 = regs[id_rs2];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] r1,
                       input logic [4:0] r2,
                       input logic u2,
                       input logic [4:0] rd,
                       input logic [7:0] c);
    id_valid = v; id_rs1 = r1; id_rs2 = r2;
    id_use_rs2 = u2; id_rd = rd; id_ctrl = c;
  endtask

  // ---------------- reference model ----------------
  logic m_valid;
  logic [31:0] m_rs1v, m_rs2v, m_imm, m_pc;
  logic [4:0] m_rd, m_rs1i, m_rs2i;
  logic [7:0] m_ctrl;
  int m_cnt;

  task automatic model_reset;
    m_valid = 0; m_rs1v = 0; m_rs2v = 0;
    m_imm = 0; m_pc = 0; m_rd = 0;
    m_rs1i = 0; m_rs2i = 0; m_ctrl = 0;
    m_cnt = 0;
  endtask

  // Architectural value the instruction in ID should see.
  function automatic logic [31:0] cap_val(
    input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef RVDP_WB_BYPASS_EN
    if (wb_we && wb_rd == r) return wb_wd;
`endif
    return regs[r];
  endfunction

  task automatic model_step(output logic st);
    logic lu, dep;
    lu = m_valid && m_ctrl[6] && m_rd != 0
      && id_valid && (m_rd == id_rs1
      || (id_use_rs2 && m_rd == id_rs2));
    dep = 1'b0;
`ifndef RVDP_WB_BYPASS_EN
    dep = wb_we && wb_rd != 0 && id_valid
      && (wb_rd == id_rs1
      || (id_use_rs2 && wb_rd == id_rs2));
`endif
    st = (lu || dep || hold_ex) && !flush_ex;
    if (flush_ex) begin
      m_valid = 0; m_ctrl = 0;
    end else if (hold_ex) begin
      if (m_valid && wb_we && wb_rd != 0) begin
        if (wb_rd == m_rs1i) m_rs1v = wb_wd;
        if (wb_rd == m_rs2i) m_rs2v = wb_wd;
      end
    end else if (lu || dep) begin
      m_valid = 0; m_ctrl = 0;
      if (m_cnt < SAT) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_rs1v = cap_val(id_rs1);
      m_rs2v = cap_val(id_rs2);
      m_imm = id_imm; m_pc = id_pc;
      m_rd = id_rd; m_ctrl = id_ctrl;
      m_rs1i = id_rs1; m_rs2i = id_rs2;
    end
  endtask

  task automatic cmp_model;
    chk("rnd_valid", 64'(ex_valid), 64'(m_valid));
    chk("rnd_rs1", 64'(ex_rs1_val), 64'(m_rs1v));
    chk("rnd_rs2", 64'(ex_rs2_val), 64'(m_rs2v));
    chk("rnd_imm", 64'(ex_imm), 64'(m_imm));
    chk("rnd_pc", 64'(ex_pc), 64'(m_pc));
    chk("rnd_rd", 64'(ex_rd), 64'(m_rd));
    chk("rnd_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
    chk("rnd_cnt", 64'(bubble_cnt), 64'(m_cnt));
  endtask

  task automatic run_random(input int n);
    logic st_exp;
    logic stalled;
    stalled = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!stalled) begin
        id_valid = ($urandom_range(7) != 0);
        id_rs1 = 5'($urandom_range(7));
        id_rs2 = 5'($urandom_range(7));
        id_use_rs2 = 1'($urandom_range(1));
        id_rd = 5'($urandom_range(7));
        id_ctrl = 8'($urandom);
        id_imm = $urandom;
        id_pc = $urandom;
      end
      wb_we = 1'($urandom_range(1));
      wb_rd = 5'($urandom_range(7));
      wb_wd = $urandom;
      flush_ex = ($urandom_range(15) == 0);
      hold_ex = ($urandom_range(7) == 0);
      #1;
      model_step(st_exp);
      chk("rnd_stall", 64'(stall_id), 64'(st_exp));
      stalled = st_exp;
      tick;
      cmp_model();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, "_rs1"}, 64'(ex_rs1_val), 64'd0);
    chk({tag, "_rs2"}, 64'(ex_rs2_val), 64'd0);
    chk({tag, "_imm"}, 64'(ex_imm), 64'd0);
    chk({tag, "_pc"}, 64'(ex_pc), 64'd0);
    chk({tag, "_rd"}, 64'(ex_rd), 64'd0);
    chk({tag, "_ctrl"}, 64'(ex_ctrl), 64'd0);
    chk({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
    chk({tag, "_stall"}, 64'(stall_id), 64'd0);
  endtask

  // Reset asserted between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    wb_we = 0; hold_ex = 0; flush_ex = 0;
    #1;
    chk_zero(tag);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use2;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbwd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tv [7];

  initial begin
    tv[0] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0,
              32'h11111111, 32'h22222222};
    tv[1] = '{5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 32'h1234,
              32'h0, 32'h33333333};
    tv[2] = '{5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,
              32'h44444444, 32'h0};
    tv[3] = '{5'd5, 5'd6, 1'b0, 1'b1, 5'd31, 32'hFEEDFACE,
              32'h55555555, 32'h66666666};
    tv[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h1234,
              32'h0, 32'h0};
    tv[5] = '{5'd9, 5'd8, 1'b1, 1'b0, 5'd0, 32'h0,
              32'h99999999, 32'h88888888};
    tv[6] = '{5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,
              32'h77777777, 32'h77777777};

    RST = 1'b0; rf_init = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    id_imm = 0; id_pc = 0;
    wb_we = 0; wb_rd = 0; wb_wd = 0;
    flush_ex = 0; hold_ex = 0;
    model_reset();
    repeat (3) tick;
    rf_init = 1'b0;
    chk_zero("rst0");
    @(negedge CLK);
    RST = 1'b1;

    for (int k = 0; k < 7; k++) begin
      drive(1, tv[k].rs1, tv[k].rs2, tv[k].use2,
            5'(10 + k), 8'(8'h80 | k));
      id_imm = 32'h1000 + k;
      id_pc = 32'h100 + 4 * k;
      wb_we = tv[k].wbwe;
      wb_rd = tv[k].wbrd;
      wb_wd = tv[k].wbwd;
      #1;
      chk("tbl_stall", 64'(stall_id), 64'd0);
      tick;
      chk("tbl_valid", 64'(ex_valid), 64'd1);
      chk("tbl_rs1", 64'(ex_rs1_val), 64'(tv[k].e1));
      chk("tbl_rs2", 64'(ex_rs2_val), 64'(tv[k].e2));
      chk("tbl_imm", 64'(ex_imm), 64'(32'h1000 + k));
    end
    wb_we = 0;

    // lw x5 ; add x6,x5,x1
    drive(1, 5'd1, 5'd0, 0, 5'd5, 8'hD0);
    #1;
    chk("lu_stall0", 64'(stall_id), 64'd0);
    tick;
    chk("lu_lw_valid", 64'(ex_valid), 64'd1);
    chk("lu_lw_rd", 64'(ex_rd), 64'd5);
    drive(1, 5'd5, 5'd1, 1, 5'd6, 8'h80);
    #1;
    chk("lu_stall1", 64'(stall_id), 64'd1);
    tick;
    exp_cnt = 1;
    chk("lu_bub_valid", 64'(ex_valid), 64'd0);
    chk("lu_bub_ctrl", 64'(ex_ctrl), 64'd0);
    chk("lu_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    chk("lu_stall2", 64'(stall_id), 64'd0);
    tick;
    chk("lu_add_valid", 64'(ex_valid), 64'd1);
    chk("lu_add_rs1", 64'(ex_rs1_val), 64'h55555555);
    chk("lu_add_rs2", 64'(ex_rs2_val), 64'h11111111);
    chk("lu_add_rd", 64'(ex_rd), 64'd6);

    // WB writes x7 while ID reads x7
    drive(1, 5'd7, 5'd0, 0, 5'd8, 8'h80);
    wb_we = 1; wb_rd = 5'd7; wb_wd = 32'hDEADBEEF;
    #1;
`ifdef RVDP_WB_BYPASS_EN
    chk("byp_stall", 64'(stall_id), 64'd0);
    tick;
    wb_we = 0;
`else
    chk("byp_stall", 64'(stall_id), 64'd1);
    tick;
    wb_we = 0;
    exp_cnt++;
    chk("byp_bub_valid", 64'(ex_valid), 64'd0);
    chk("byp_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    tick;
`endif
    chk("byp_valid", 64'(ex_valid), 64'd1);
    chk("byp_rs1", 64'(ex_rs1_val), 64'hDEADBEEF);

    // flush + hold + load_use together
    drive(1, 5'd1, 5'd0, 0, 5'd9, 8'hD0);
    tick;
    chk("fh_lw_valid", 64'(ex_valid), 64'd1);
    drive(1, 5'd9, 5'd0, 0, 5'd10, 8'h80);
    hold_ex = 1;
    #1;
    chk("fh_hold_stall", 64'(stall_id), 64'd1);
    flush_ex = 1;
    #1;
    chk("fh_stall", 64'(stall_id), 64'd0);
    tick;
    chk("fh_valid", 64'(ex_valid), 64'd0);
    chk("fh_ctrl", 64'(ex_ctrl), 64'd0);
    chk("fh_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    flush_ex = 0; hold_ex = 0;

    // hold 3 cycles with WB refresh of held operands
    drive(1, 5'd2, 5'd3, 1, 5'd12, 8'h85);
    id_imm = 32'h00000FFC; id_pc = 32'h400;
    tick;
    chk("hd_valid0", 64'(ex_valid), 64'd1);
    chk("hd_rs1_0", 64'(ex_rs1_val), 64'h22222222);
    chk("hd_rs2_0", 64'(ex_rs2_val), 64'h33333333);
    drive(1, 5'd4, 5'd6, 1, 5'd13, 8'h81);
    id_imm = 32'h1; id_pc = 32'h2;
    hold_ex = 1;
    wb_we = 1; wb_rd = 5'd3; wb_wd = 32'hCAFEF00D;
    #1;
    chk("hd_stall", 64'(stall_id), 64'd1);
    tick;
    chk("hd_rs2_1", 64'(ex_rs2_val), 64'hCAFEF00D);
    chk("hd_rs1_1", 64'(ex_rs1_val), 64'h22222222);
    wb_we = 0;
    tick;
    chk("hd_rs2_2", 64'(ex_rs2_val), 64'hCAFEF00D);
    chk("hd_imm", 64'(ex_imm), 64'h00000FFC);
    chk("hd_pc", 64'(ex_pc), 64'h400);
    chk("hd_rd", 64'(ex_rd), 64'd12);
    wb_we = 1; wb_rd = 5'd2; wb_wd = 32'h0BADF00D;
    tick;
    chk("hd_rs1_3", 64'(ex_rs1_val), 64'h0BADF00D);
    chk("hd_rs2_3", 64'(ex_rs2_val), 64'hCAFEF00D);
    chk("hd_ctrl", 64'(ex_ctrl), 64'h85);
    chk("hd_valid3", 64'(ex_valid), 64'd1);
    chk("hd_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    hold_ex = 0; wb_we = 0;

    // counter saturation: load then dependent, repeated
    for (int b = 0; b < SAT + 80; b++) begin
      drive(1, 5'd1, 5'd0, 0, 5'd5, 8'hD0);
      tick;
      drive(1, 5'd5, 5'd1, 0, 5'd6, 8'h80);
      tick;
      if (exp_cnt < SAT) exp_cnt++;
      chk("sat_cnt", 64'(bubble_cnt), 64'(exp_cnt));
    end
    chk("sat_final", 64'(bubble_cnt), 64'(SAT));

    async_reset("rst1");
    run_random(800);
    async_reset("rst2");
    run_random(700);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
